vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port synchronous video RAM (1-clock read latency) between the pixel-fetch datapath and the Z80 CPU bus.
- Video fetch has fixed-phase priority. The CPU is served in free slots via a req/ack handshake plus a WAIT output.
- A starvation limit forces a CPU slot, dropping one video fetch ("snow", as on the original machine).
- Also owns the VRAM bank register that maps the 2 KB CPU window into the 32 KB VRAM space.

Parameters:
ADDR_W, 15, VRAM address width
CPU_ADDR_W, 11, CPU window offset width (2 KB)
BANK_W, 4, bank register width; ADDR_W = BANK_W + CPU_ADDR_W
MAX_WAIT, 16, max consecutive slots the CPU may lose (legal range 1..255)

Ports:
pixel_clock  in  1  sole clock
reset  in  1  synchronous, active-low
vid_req  in  1  video fetch strobe, one cycle
vid_addr  in  ADDR_W  video fetch address
vid_data  out  8  fetched byte; held until next completed video read
vid_valid  out  1  one-cycle pulse, vid_data updated
vid_miss  out  1  one-cycle pulse, a vid_req was dropped for the CPU
cpu_req  in  1  level; held until cpu_ack
cpu_we  in  1  1 = write
cpu_addr  in  CPU_ADDR_W  offset within window
cpu_wdata  in  8  write data
cpu_rdata  out  8  read data, valid while cpu_ack
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  Z80 WAIT request
bank_we  in  1  load bank register
bank_data  in  BANK_W  new bank
bank  out  BANK_W  current bank
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write strobe
ram_wdata  out  8  registered RAM write data
ram_rdata  in  8  RAM read data, 1 clock after ram_addr

Behaviour:
- Reset (reset==0 at an edge): all outputs 0, bank 0, CPU FSM IDLE, wait_cnt 0, slot pipeline tags NONE.
- Slot decision, combinational each cycle k, exactly one grant:
  - CPU if the CPU FSM is PEND/IDLE with a request and (no vid_req or wait_cnt==MAX_WAIT).
  - Else VIDEO if vid_req.
  - Else NONE.
- Pipeline:
  - Cycle k+1: ram_addr/ram_we/ram_wdata driven for the grant. ram_we=1 only for a CPU write. On NONE, ram_we=0 and ram_addr holds.
  - Cycle k+2: ram_rdata valid.
  - Cycle k+3, VIDEO grant: vid_data=captured byte, vid_valid=1.
  - Cycle k+3, CPU grant: cpu_ack=1; cpu_rdata=captured byte for reads, unchanged for writes.
  - Fixed 3-cycle latency for every grant type. Tags travel in a 2-stage shift register.
- CPU FSM:
  - IDLE: on cpu_req, latch {bank,cpu_addr}, cpu_we, cpu_wdata. If granted this cycle → BUSY, else → PEND.
  - PEND: granted → BUSY; otherwise stay and wait_cnt++.
  - BUSY: → ACK when the tag reaches the capture stage.
  - ACK: cpu_ack=1 for one cycle → RELEASE.
  - RELEASE: → IDLE once cpu_req==0. Req held high after ack does not start a second access.
  - wait_cnt clears on grant.
- cpu_wait = cpu_req & state∉{ACK,RELEASE}.
- Forced slot: when wait_cnt==MAX_WAIT and vid_req=1, the CPU wins and vid_miss pulses in cycle k. No vid_valid follows for that request and vid_data holds.
- A CPU-granted slot with no vid_req never pulses vid_miss.
- Bank:
  - bank_we loads bank_data at the edge.
  - The CPU address is captured at IDLE accept, so a bank write during PEND/BUSY does not affect the in-flight access.
  - bank_we simultaneous with an accept: the old bank is used.
- Reset mid-access: the in-flight access is abandoned, no ack, and any pending RAM write is cancelled in the same edge (ram_we←0).

Decomposition:
- Package vram_arb_pkg: CPU FSM state enum (IDLE, PEND, BUSY, ACK, RELEASE), slot tag enum (NONE, VIDEO, CPU_RD, CPU_WR), default MAX_WAIT.
- Single module, no sub-module. The tag shift register and saturating wait counter stay inline.

Test Plan:
1. Video only: vid_req=1, vid_addr=0x0123 at cycle 0, RAM holds 0x5A → ram_addr=0x0123 at cycle 1; vid_valid=1, vid_data=0x5A at cycle 3; no cpu_ack.
2. CPU read, idle bus: bank=2, cpu_req read at cpu_addr=0x010, RAM[0x1010]=0xC3 → cpu_wait high cycles 0-2; cpu_ack and cpu_rdata=0xC3 at cycle 3; cpu_req held high afterward yields no second ack.
3. Collision: vid_req and CPU write 0x77 to offset 0 both at cycle 0 → video issued cycle 1, ram_we=1 at cycle 2, cpu_ack at cycle 4, vid_valid at cycle 3.
4. Starvation: MAX_WAIT=4, vid_req every cycle, CPU read pending → CPU granted on the 5th slot, vid_miss pulses that cycle, exactly one vid_valid missing.
5. Bank race: cpu_req accepted at bank=1 and bank_we=1 with bank_data=3 in the same cycle → ram_addr upper bits=1, bank reads 3 afterward.
6. Reset mid-write: reset=0 in the cycle after a CPU write grant → ram_we=0 after that edge, cpu_ack never asserts, all outputs 0.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared types.
// CPU handshake states, RAM slot tags and defaults.
package vram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_BUSY,
    ST_ACK,
    ST_RELEASE
  } cpu_st_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VIDEO,
    TAG_CPU_RD,
    TAG_CPU_WR
  } slot_tag_e;

  localparam int unsigned MAX_WAIT_DEF = 16;
  localparam int unsigned WAIT_W       = 8;

  function automatic logic tag_is_cpu(
    input slot_tag_e t
  );
    return (t == TAG_CPU_RD) ||
           (t == TAG_CPU_WR);
  endfunction

endpackage

// File: rtl/vram_arbiter.sv
// VRAM arbiter: video fetch vs. Z80 bus.
// Fixed 3-cycle slot pipeline, forced CPU slot on starvation.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned CPU_ADDR_W = 11,
  parameter int unsigned BANK_W     = 4,
  parameter int unsigned MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  pixel_clock,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [ADDR_W-1:0]     vid_addr,
  output logic [7:0]            vid_data,
  output logic                  vid_valid,
  output logic                  vid_miss,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [CPU_ADDR_W-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_wait,
  input  logic                  bank_we,
  input  logic [BANK_W-1:0]     bank_data,
  output logic [BANK_W-1:0]     bank,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata
);

  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(MAX_WAIT);

  cpu_st_e            st_q, st_d;
  slot_tag_e          tag0_q, tag0_d;
  slot_tag_e          tag1_q, tag1_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BANK_W-1:0]  bank_q, bank_d;

  logic [ADDR_W-1:0]  lat_addr_q, lat_addr_d;
  logic               lat_we_q, lat_we_d;
  logic [7:0]         lat_wdata_q, lat_wdata_d;

  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               ram_we_q, ram_we_d;
  logic [7:0]         ram_wdata_q, ram_wdata_d;

  logic [7:0]         vid_data_q, vid_data_d;
  logic               vid_valid_q, vid_valid_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ack_q, cpu_ack_d;

  logic               cpu_cand;
  logic               forced;
  logic               grant_cpu;
  logic               grant_vid;
  logic [ADDR_W-1:0]  acc_addr;
  logic               acc_we;
  logic [7:0]         acc_wdata;

  // Slot decision: CPU yields to video unless starved.
  always_comb begin
    cpu_cand  = (st_q == ST_PEND) |
                ((st_q == ST_IDLE) & cpu_req);
    forced    = (wait_q == WAIT_LIM);
    grant_cpu = cpu_cand & (~vid_req | forced);
    grant_vid = vid_req & ~grant_cpu;
  end

  // A fresh request is issued straight from the bus.
  always_comb begin
    if (st_q == ST_IDLE) begin
      acc_addr  = {bank_q, cpu_addr};
      acc_we    = cpu_we;
      acc_wdata = cpu_wdata;
    end else begin
      acc_addr  = lat_addr_q;
      acc_we    = lat_we_q;
      acc_wdata = lat_wdata_q;
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag0_d      = TAG_NONE;
    unique case (1'b1)
      grant_cpu: begin
        ram_addr_d  = acc_addr;
        ram_we_d    = acc_we;
        ram_wdata_d = acc_wdata;
        tag0_d      = acc_we ? TAG_CPU_WR
                             : TAG_CPU_RD;
      end
      grant_vid: begin
        ram_addr_d = vid_addr;
        tag0_d     = TAG_VIDEO;
      end
      default: ;
    endcase
  end

  always_comb begin
    tag1_d      = tag0_q;
    vid_valid_d = (tag1_q == TAG_VIDEO);
    vid_data_d  = vid_valid_d ? ram_rdata
                              : vid_data_q;
    cpu_ack_d   = tag_is_cpu(tag1_q);
    cpu_rdata_d = (tag1_q == TAG_CPU_RD)
                  ? ram_rdata : cpu_rdata_q;
    bank_d      = bank_we ? bank_data : bank_q;
  end

  always_comb begin
    st_d        = st_q;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    unique case (st_q)
      ST_IDLE: begin
        if (cpu_req) begin
          lat_addr_d  = acc_addr;
          lat_we_d    = acc_we;
          lat_wdata_d = acc_wdata;
          st_d = grant_cpu ? ST_BUSY : ST_PEND;
        end
      end
      ST_PEND: begin
        if (grant_cpu) st_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (tag_is_cpu(tag1_q)) st_d = ST_ACK;
      end
      ST_ACK: st_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!cpu_req) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // Counts lost slots; saturates at the limit.
  always_comb begin
    wait_d = wait_q;
    if (grant_cpu || !cpu_cand) begin
      wait_d = '0;
    end else if (!forced) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      tag0_q      <= TAG_NONE;
      tag1_q      <= TAG_NONE;
      wait_q      <= '0;
      bank_q      <= '0;
      lat_addr_q  <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      vid_data_q  <= '0;
      vid_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      wait_q      <= wait_d;
      bank_q      <= bank_d;
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      vid_data_q  <= vid_data_d;
      vid_valid_q <= vid_valid_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign vid_data  = vid_data_q;
  assign vid_valid = vid_valid_q;
  assign vid_miss  = grant_cpu & vid_req;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_wait  = cpu_req &
                     (st_q != ST_ACK) &
                     (st_q != ST_RELEASE);
  assign bank      = bank_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// vram_arbiter bench: grant-log reference model
// plus directed literal checks and random traffic.
module tb_vram_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [14:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_miss;
  logic        cpu_req;
  logic        cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;
  logic        bank_we;
  logic [3:0]  bank_data;
  logic [3:0]  bank;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic        bd_we;
  logic [14:0] bd_addr;
  logic [7:0]  bd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(15), .CPU_ADDR_W(11),
    .BANK_W(4), .MAX_WAIT(MW)
  ) dut (
    .pixel_clock(clk),
    .reset(reset),
    .vid_req(vid_req),
    .vid_addr(vid_addr),
    .vid_data(vid_data),
    .vid_valid(vid_valid),
    .vid_miss(vid_miss),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
    .cpu_wait(cpu_wait),
    .bank_we(bank_we),
    .bank_data(bank_data),
    .bank(bank),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Physical single-port RAM, 1-clock read.
  bit [7:0] phys [32768];
  always @(posedge clk) begin
    if (ram_we) phys[ram_addr] <= ram_wdata;
    if (bd_we) phys[bd_addr] <= bd_data;
    ram_rdata <= phys[ram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: a log of granted slots ----
  typedef struct {
    int         typ;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rbyte;
  } gr_t;

  gr_t         hist [8];
  gr_t         p1, p3, g;
  bit [7:0]    mem_m [32768];
  int          m_state = 0;
  int          m_lost = 0;
  int          m_gcyc = 0;
  logic [3:0]  m_bank = 0;
  logic [14:0] m_addr = 0;
  logic        m_we = 0;
  logic [7:0]  m_wdata = 0;
  logic [14:0] last_addr = 0;
  logic [7:0]  held_vd = 0;
  logic [7:0]  held_rd = 0;
  bit          armed = 0;
  bit          ack_now, cand, win;
  bit          e_wait, e_miss;

  always @(negedge clk) begin
    p1 = hist[(cyc + 7) % 8];
    p3 = hist[(cyc + 5) % 8];
    if (p1.typ != 0) last_addr = p1.addr;
    if (p1.typ == 3) mem_m[p1.addr] = p1.wdata;
    if (bd_we) mem_m[bd_addr] = bd_data;
    if (p3.typ == 1) held_vd = p3.rbyte;
    if (p3.typ == 2) held_rd = p3.rbyte;

    ack_now = (m_state == 2) &&
              (cyc == m_gcyc + 3);
    e_wait  = cpu_req && !ack_now &&
              (m_state != 3);
    cand    = (m_state == 1) ||
              (m_state == 0 && cpu_req);
    if (m_state == 0 && cpu_req) begin
      m_addr  = {m_bank, cpu_addr};
      m_we    = cpu_we;
      m_wdata = cpu_wdata;
    end
    win    = cand && (!vid_req || m_lost == MW);
    e_miss = win && vid_req;
    g = '{0, 15'h0, 8'h0, 8'h0};
    if (win) begin
      g.typ   = m_we ? 3 : 2;
      g.addr  = m_addr;
      g.wdata = m_wdata;
      g.rbyte = mem_m[m_addr];
    end else if (vid_req) begin
      g.typ   = 1;
      g.addr  = vid_addr;
      g.rbyte = mem_m[vid_addr];
    end

    if (armed) begin
      chk("ram_we", ram_we, p1.typ == 3);
      chk("ram_addr", ram_addr, last_addr);
      if (p1.typ == 3)
        chk("ram_wdata", ram_wdata, p1.wdata);
      chk("vid_valid", vid_valid, p3.typ == 1);
      chk("vid_data", vid_data, held_vd);
      chk("cpu_ack", cpu_ack, p3.typ >= 2);
      chk("cpu_rdata", cpu_rdata, held_rd);
      chk("vid_miss", vid_miss, e_miss);
      chk("cpu_wait", cpu_wait, e_wait);
      chk("bank", bank, m_bank);
    end

    if (ack_now) m_state = 3;
    else if (m_state == 3 && !cpu_req)
      m_state = 0;
    if (cand) begin
      if (win) begin
        m_state = 2;
        m_gcyc  = cyc;
        m_lost  = 0;
      end else begin
        m_state = 1;
        if (m_lost < MW) m_lost++;
      end
    end
    if (bank_we) m_bank = bank_data;
    hist[cyc % 8] = g;

    if (!reset) begin
      for (int i = 0; i < 8; i++)
        hist[i] = '{0, 15'h0, 8'h0, 8'h0};
      m_state = 0; m_lost = 0;
      m_bank = 0; last_addr = 0;
      held_vd = 0; held_rd = 0;
      armed = 1;
    end
  end

  function automatic logic [14:0] rnd_addr();
    logic [3:0] b;
    logic [3:0] o;
    b = 4'($urandom_range(0, 3));
    o = 4'($urandom);
    return {b, 7'h0, o};
  endfunction

  int  miss_at, miss_n, nv;
  int  rel_left, busy;
  bit  got_ack;

  initial begin
    reset = 0; vid_req = 0; vid_addr = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0;
    cpu_wdata = 0; bank_we = 0; bank_data = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    repeat (3) tick();
    reset = 1;
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_bank", bank, 0);
    chk("rst_vid_data", vid_data, 0);

    tick(); bd_we = 1;
    bd_addr = 15'h0123; bd_data = 8'h5a;
    tick(); bd_addr = 15'h1010; bd_data = 8'hc3;
    tick(); bd_we = 0;

    // 1: video only
    tick(); vid_req = 1; vid_addr = 15'h0123;
    tick(); vid_req = 0;
    @(negedge clk);
    chk("t1_ram_addr", ram_addr, 15'h0123);
    tick(); tick();
    @(negedge clk);
    chk("t1_vid_valid", vid_valid, 1);
    chk("t1_vid_data", vid_data, 8'h5a);
    chk("t1_no_ack", cpu_ack, 0);

    // 2: CPU read on idle bus, bank 2
    tick(); bank_we = 1; bank_data = 2;
    tick(); bank_we = 0;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'h010;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      chk("t2_wait", cpu_wait, 1);
    end
    tick(); @(negedge clk);
    chk("t2_ack", cpu_ack, 1);
    chk("t2_rdata", cpu_rdata, 8'hc3);
    repeat (4) begin
      tick(); @(negedge clk);
      chk("t2_no_second_ack", cpu_ack, 0);
    end
    tick(); cpu_req = 0;
    repeat (2) tick();

    // 3: collision, video first
    tick();
    vid_req = 1; vid_addr = 15'h0200;
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 11'h000; cpu_wdata = 8'h77;
    tick(); vid_req = 0;
    @(negedge clk);
    chk("t3_vid_addr", ram_addr, 15'h0200);
    chk("t3_vid_no_we", ram_we, 0);
    tick(); @(negedge clk);
    chk("t3_we", ram_we, 1);
    chk("t3_wr_addr", ram_addr, 15'h1000);
    chk("t3_wdata", ram_wdata, 8'h77);
    tick(); @(negedge clk);
    chk("t3_vid_valid", vid_valid, 1);
    chk("t3_ack_early", cpu_ack, 0);
    tick(); @(negedge clk);
    chk("t3_ack", cpu_ack, 1);
    tick(); cpu_req = 0; cpu_we = 0;
    repeat (2) tick();

    // 4: starvation with MAX_WAIT=4
    miss_at = -1; miss_n = 0; nv = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0;
        cpu_addr = 11'h010;
      end
      if (c == 8) cpu_req = 0;
      vid_req = (c < 8);
      vid_addr = 15'h0123;
      @(negedge clk);
      if (vid_miss) begin
        miss_n++;
        miss_at = c;
      end
      if (vid_valid) nv++;
      if (c == 7) begin
        chk("t4_ack", cpu_ack, 1);
        chk("t4_hole", vid_valid, 0);
        chk("t4_vd_hold", vid_data, 8'h5a);
      end
    end
    chk("t4_miss_cycle", miss_at, 4);
    chk("t4_miss_count", miss_n, 1);
    chk("t4_valid_count", nv, 7);

    // 5: bank write races an accept
    tick(); bank_we = 1; bank_data = 1;
    tick(); bank_we = 0;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 11'h005;
    bank_we = 1; bank_data = 3;
    tick(); bank_we = 0;
    @(negedge clk);
    chk("t5_bank_bits", ram_addr[14:11], 4'd1);
    chk("t5_ram_addr", ram_addr, 15'h0805);
    chk("t5_bank_new", bank, 4'd3);
    tick(); tick(); tick();
    cpu_req = 0;
    repeat (2) tick();

    // 6: reset mid-write
    tick();
    cpu_req = 1; cpu_we = 1;
    cpu_addr = 11'h020; cpu_wdata = 8'hab;
    tick(); reset = 0; cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    chk("t6_we_issued", ram_we, 1);
    tick(); reset = 1;
    @(negedge clk);
    chk("t6_we_cancel", ram_we, 0);
    chk("t6_ram_addr", ram_addr, 0);
    chk("t6_bank", bank, 0);
    chk("t6_vid_valid", vid_valid, 0);
    chk("t6_cpu_rdata", cpu_rdata, 0);
    chk("t6_cpu_wait", cpu_wait, 0);
    for (int c = 0; c < 4; c++) begin
      chk("t6_no_ack", cpu_ack, 0);
      tick(); @(negedge clk);
    end

    // random traffic against the model
    rel_left = -1; busy = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      got_ack = cpu_ack;
      tick();
      reset = ($urandom_range(0, 599) != 0);
      vid_req = ($urandom_range(0, 2) != 0);
      vid_addr = rnd_addr();
      bank_we = ($urandom_range(0, 7) == 0);
      bank_data = 4'($urandom_range(0, 3));
      bd_we = ($urandom_range(0, 5) == 0);
      bd_addr = rnd_addr();
      bd_data = 8'($urandom);
      if (!reset) begin
        cpu_req = 0; rel_left = -1; busy = 0;
      end else if (cpu_req) begin
        if (got_ack && rel_left < 0) begin
          chk("ack_wait_bound", busy > 40, 0);
          rel_left = $urandom_range(0, 2);
        end
        if (rel_left == 0) begin
          cpu_req = 0; rel_left = -1;
        end else if (rel_left > 0) begin
          rel_left--;
        end else begin
          busy++;
          if (busy > 40) begin
            chk("ack_wait_bound", busy > 40, 0);
            cpu_req = 0; busy = 0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_req = 1; busy = 0;
        cpu_we = 1'($urandom);
        cpu_addr = {7'h0, 4'($urandom)};
        cpu_wdata = 8'($urandom);
      end
    end
    tick();
    vid_req = 0; cpu_req = 0;
    bank_we = 0; bd_we = 0; reset = 1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
